// File: rtl/ldst_request_queue_if.sv
// Pipeline-side request, memory request/response and Mem/Wb retire signals of the ld/st queue.
// The queue uses the master view; the pipeline/memory environment uses the slave view.
interface ldst_request_queue_if;
    logic        req_valid;
    logic        req_rw;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [15:0] req_ctrl;
    logic [3:0]  req_z;
    logic        pipe_stall;

    logic        mem_valid;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_id;
    logic        mem_stall_in;
    logic        mem_ready_in;
    logic [3:0]  mem_id_in;
    logic [31:0] mem_data_in;

    logic        wb_valid;
    logic        wb_rw;
    logic [31:0] wb_data;
    logic [15:0] wb_ctrl;
    logic [3:0]  wb_z;
    logic        resp_err;

    modport master (
        input  req_valid, req_rw, req_addr, req_wdata, req_ctrl, req_z,
        input  mem_stall_in, mem_ready_in, mem_id_in, mem_data_in,
        output pipe_stall, mem_valid, mem_rw, mem_addr, mem_data, mem_id,
        output wb_valid, wb_rw, wb_data, wb_ctrl, wb_z, resp_err
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_wdata, req_ctrl, req_z,
        output mem_stall_in, mem_ready_in, mem_id_in, mem_data_in,
        input  pipe_stall, mem_valid, mem_rw, mem_addr, mem_data, mem_id,
        input  wb_valid, wb_rw, wb_data, wb_ctrl, wb_z, resp_err
    );
endinterface

// File: rtl/ldst_request_queue.sv
// In-order load/store request queue: allocates at tail, issues to memory in order,
// accepts out-of-order responses by id and retires in program order to Mem/Wb.
module ldst_request_queue #(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    ldst_request_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_WAIT_ISSUE,
        ST_ISSUED,
        ST_DONE
    } entry_state_e;

    entry_state_e state_q [DEPTH];
    entry_state_e state_d [DEPTH];
    logic         rw_q    [DEPTH];
    logic         rw_d    [DEPTH];
    logic [31:0]  addr_q  [DEPTH];
    logic [31:0]  addr_d  [DEPTH];
    logic [31:0]  wdata_q [DEPTH];
    logic [31:0]  wdata_d [DEPTH];
    logic [15:0]  ctrl_q  [DEPTH];
    logic [15:0]  ctrl_d  [DEPTH];
    logic [3:0]   z_q     [DEPTH];
    logic [3:0]   z_d     [DEPTH];
    logic [31:0]  rdata_q [DEPTH];
    logic [31:0]  rdata_d [DEPTH];

    logic [PTR_W-1:0] tail_q, tail_d, issue_q, issue_d, head_q, head_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_rw_q, wb_rw_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [15:0] wb_ctrl_q, wb_ctrl_d;
    logic [3:0]  wb_z_q, wb_z_d;
    logic        resp_err_q, resp_err_d;

    logic             do_enq, do_issue, do_retire, resp_hit;
    logic [PTR_W-1:0] resp_idx;

    // Full is judged on the registered count only, so a same-cycle retire never unblocks it.
    assign bus.pipe_stall = (count_q == CNT_W'(DEPTH));
    assign bus.mem_valid  = (state_q[issue_q] == ST_WAIT_ISSUE);
    assign bus.mem_rw     = rw_q[issue_q];
    assign bus.mem_addr   = addr_q[issue_q];
    assign bus.mem_data   = wdata_q[issue_q];
    assign bus.mem_id     = 4'(issue_q);

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rw    = wb_rw_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_ctrl  = wb_ctrl_q;
    assign bus.wb_z     = wb_z_q;
    assign bus.resp_err = resp_err_q;

    assign do_enq    = bus.req_valid && !bus.pipe_stall;
    assign do_issue  = bus.mem_valid && !bus.mem_stall_in;
    assign do_retire = (state_q[head_q] == ST_DONE);
    assign resp_idx  = bus.mem_id_in[PTR_W-1:0];
    assign resp_hit  = (int'(bus.mem_id_in) < DEPTH) && (state_q[resp_idx] == ST_ISSUED);

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ctrl_d     = ctrl_q;
        z_d        = z_q;
        rdata_d    = rdata_q;
        tail_d     = tail_q;
        issue_d    = issue_q;
        head_d     = head_q;
        count_d    = count_q;
        wb_valid_d = 1'b0;
        wb_rw_d    = wb_rw_q;
        wb_data_d  = wb_data_q;
        wb_ctrl_d  = wb_ctrl_q;
        wb_z_d     = wb_z_q;
        resp_err_d = resp_err_q;

        if (do_enq) begin
            state_d[tail_q] = ST_WAIT_ISSUE;
            rw_d[tail_q]    = bus.req_rw;
            addr_d[tail_q]  = bus.req_addr;
            wdata_d[tail_q] = bus.req_wdata;
            ctrl_d[tail_q]  = bus.req_ctrl;
            z_d[tail_q]     = bus.req_z;
            tail_d          = tail_q + 1'b1;
        end

        if (do_issue) begin
            state_d[issue_q] = ST_ISSUED;
            issue_d          = issue_q + 1'b1;
        end

        // The four actions act on entries in four distinct states, so they never collide.
        if (bus.mem_ready_in) begin
            if (resp_hit) begin
                state_d[resp_idx] = ST_DONE;
                rdata_d[resp_idx] = bus.mem_data_in;
            end else begin
                resp_err_d = 1'b1;
            end
        end

        if (do_retire) begin
            state_d[head_q] = ST_FREE;
            head_d          = head_q + 1'b1;
            wb_valid_d      = 1'b1;
            wb_rw_d         = rw_q[head_q];
            wb_data_d       = rdata_q[head_q];
            wb_ctrl_d       = ctrl_q[head_q];
            wb_z_d          = z_q[head_q];
        end

        if (do_enq && !do_retire) begin
            count_d = count_q + 1'b1;
        end else if (!do_enq && do_retire) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '{default: ST_FREE};
            tail_q     <= '0;
            issue_q    <= '0;
            head_q     <= '0;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_ctrl_q  <= '0;
            wb_z_q     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tail_q     <= tail_d;
            issue_q    <= issue_d;
            head_q     <= head_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_z_q     <= wb_z_d;
            resp_err_q <= resp_err_d;
        end
    end

    // NOTE: payload storage is not reset; an entry's state alone decides whether its payload is live.
    always_ff @(posedge clk) begin
        rw_q    <= rw_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        ctrl_q  <= ctrl_d;
        z_q     <= z_d;
        rdata_q <= rdata_d;
    end
endmodule
